// File: rtl/mem_access_pkg.sv
// Shared definitions for the multicycle memory access unit: FSM encoding,
// default timeout and address alignment helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } mau_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mau_wdog.sv
// BUSY wait counter: counts from 0 while enabled and flags when the
// TIMEOUT-1 limit has been reached.
module mau_wdog
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns controller MemRead/MemWrite strobes into a
// req/ack memory transaction and stalls the controller until it completes.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; request latched on detect
// BUSY  | mem_req held, waiting for mem_ack under watchdog
// DONE  | one cycle, ir/mdr valid, stall released
// ERR   | no ack within TIMEOUT cycles; sticky until reset
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        ir_write,
  input  logic        iord,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        err
);

  mau_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic        we_q, we_d;
  logic        dest_q, dest_d;
  logic        access_req;
  logic        take_req;
  logic        ack_hit;
  logic        expired;

  assign access_req = mem_read | mem_write;
  assign take_req   = (state_q == ST_IDLE) && access_req;
  assign ack_hit    = (state_q == ST_BUSY) && mem_ack;

  mau_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ST_BUSY),
    .enable  ((state_q == ST_BUSY) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (access_req) state_d = ST_BUSY;
      ST_BUSY: begin
        // ack on the limit cycle still completes the access
        if (mem_ack)      state_d = ST_DONE;
        else if (expired) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    dest_d  = dest_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    if (take_req) begin
      addr_d  = word_align(iord ? alu_out : pc);
      wdata_d = store_data;
      we_d    = mem_write;
      dest_d  = ir_write;
    end
    // writes never load IR/MDR, even when mem_read was also asserted
    if (ack_hit && !we_q) begin
      if (dest_q) ir_d  = mem_rdata;
      else        mdr_d = mem_rdata;
    end
  end

  always_comb begin
    mem_req = (state_q == ST_BUSY);
    mem_we  = (state_q == ST_BUSY) && we_q;
    err     = (state_q == ST_ERR);
    stall   = take_req || (state_q == ST_BUSY) || (state_q == ST_ERR);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed fetch/load/store/timeout/
// reset cases followed by randomized accesses against a transaction model.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        ir_write = 1'b0;
  logic        iord = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] store_data = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        stall;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  // model of architecturally visible registers
  logic [31:0] m_ir, m_mdr, m_addr, m_wdata;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .pc         (pc),
    .alu_out    (alu_out),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .ir         (ir),
    .mdr        (mdr),
    .stall      (stall),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".ir"}, ir, m_ir);
    check({tag, ".mdr"}, mdr, m_mdr);
    check({tag, ".addr"}, mem_addr, m_addr);
    check({tag, ".wdata"}, mem_wdata, m_wdata);
  endtask

  task automatic model_reset();
    m_ir = '0; m_mdr = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"}, {31'd0, mem_req}, 32'd0);
    check({tag, ".we"}, {31'd0, mem_we}, 32'd0);
    check({tag, ".stall"}, {31'd0, stall}, 32'd0);
    check({tag, ".err"}, {31'd0, err}, 32'd0);
    check_regs(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One access; ack_at is the BUSY cycle index carrying mem_ack
  // (ack_at >= TIMEOUT means no ack and the unit must time out).
  task automatic access(input logic rd, input logic wr, input logic irw,
                        input logic iord_i, input logic [31:0] pc_i,
                        input logic [31:0] alu_i, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rdata);
    logic done;
    logic [31:0] raw;
    done = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; ir_write = irw; iord = iord_i;
    pc = pc_i; alu_out = alu_i; store_data = sd;
    #1;
    check("idle.stall", {31'd0, stall}, {31'd0, (rd | wr)});
    check("idle.req", {31'd0, mem_req}, 32'd0);
    raw = iord_i ? alu_i : pc_i;
    m_addr  = raw & 32'hFFFF_FFFC;
    m_wdata = sd;
    @(posedge clk);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      check("busy.req", {31'd0, mem_req}, 32'd1);
      check("busy.we", {31'd0, mem_we}, {31'd0, wr});
      check("busy.stall", {31'd0, stall}, 32'd1);
      if (k == 0) check_regs("busy");
      mem_ack = (k == ack_at);
      mem_rdata = rdata;
      @(posedge clk);
      if (k == ack_at) begin
        done = 1'b1;
        break;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    if (done) begin
      if (!wr) begin
        if (irw) m_ir = rdata;
        else     m_mdr = rdata;
      end
      // request inputs still asserted: DONE must ignore them
      check("done.req", {31'd0, mem_req}, 32'd0);
      check("done.stall", {31'd0, stall}, 32'd0);
      check("done.err", {31'd0, err}, 32'd0);
      check_regs("done");
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check("idle2.req", {31'd0, mem_req}, 32'd0);
      check("idle2.stall", {31'd0, stall}, 32'd0);
    end else begin
      mem_read = 1'b0; mem_write = 1'b0;
      for (int j = 0; j < 3; j++) begin
        check("err.err", {31'd0, err}, 32'd1);
        check("err.stall", {31'd0, stall}, 32'd1);
        check("err.req", {31'd0, mem_req}, 32'd0);
        check_regs("err");
        mem_ack = (j == 1);
        @(negedge clk);
      end
      mem_ack = 1'b0;
      apply_reset();
    end
  endtask

  initial begin
    logic [31:0] r0, r1, r2, r3;
    int ack_at;
    logic rd, wr;
    model_reset();
    #12;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // fetch: ack on 2nd BUSY cycle
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1, 32'h8C22_0004);
    check("fetch.ir", ir, 32'h8C22_0004);
    // load with misaligned alu_out
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0103, 32'h0, 0, 32'h1234_5678);
    check("load.mdr", mdr, 32'h1234_5678);
    check("load.ir", ir, 32'h8C22_0004);
    // store with both strobes
    access(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 2, 32'hFFFF_FFFF);
    check("store.wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store.mdr", mdr, 32'h1234_5678);
    // ack on the limit cycle wins
    access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, TIMEOUT - 1, 32'hA5A5_0001);
    // no ack at all
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0090, 32'h0, 32'h0, TIMEOUT, 32'h0);

    // spurious ack in IDLE
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("spur.req", {31'd0, mem_req}, 32'd0);
    check("spur.stall", {31'd0, stall}, 32'd0);
    check_regs("spur");

    // reset mid-BUSY
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0, 32'h0BAD_F00D);
    @(negedge clk);
    mem_read = 1'b1; ir_write = 1'b0; iord = 1'b1; alu_out = 32'h0000_0777;
    store_data = 32'h5555_AAAA;
    @(posedge clk);
    #2;
    check("midbusy.req_pre", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    mem_read = 1'b0;
    model_reset();
    #1 check_reset_outputs("midbusy");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized accesses
    for (int t = 0; t < 40; t++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      rd = r0[0]; wr = r0[1];
      if (!rd && !wr) rd = 1'b1;
      ack_at = (r0[7:4] == 4'hF) ? TIMEOUT : int'($urandom_range(0, 5));
      if (r0[9:8] == 2'b11) ack_at = TIMEOUT - 1;
      access(rd, wr, r0[2], r0[3], r1, r2, r3, ack_at, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, maximum cycles in BUSY waiting for mem_ack before declaring error.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_read  input  1  controller MemRead.
REQ-005 SHALL have port mem_write  input  1  controller MemWrite.
REQ-006 SHALL have port ir_write  input  1  controller IRWrite; read data goes to IR.
REQ-007 SHALL have port iord  input  1  controller IorD: 0 selects pc, 1 selects alu_out.
REQ-008 SHALL have port pc  input  32  program counter.
REQ-009 SHALL have port alu_out  input  32  ALUOut register, data address.
REQ-010 SHALL have port store_data  input  32  register-B value for stores.
REQ-011 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-012 SHALL have port mem_ack  input  1  memory completion strobe.
REQ-013 SHALL have port mem_req  output  1  memory request, held until ack.
REQ-014 SHALL have port mem_we  output  1  write qualifier for mem_req.
REQ-015 SHALL have port mem_addr  output  32  word address, bits [1:0] forced 0.
REQ-016 SHALL have port mem_wdata  output  32  latched store data.
REQ-017 SHALL have port ir  output  32  instruction register.
REQ-018 SHALL have port mdr  output  32  memory data register.
REQ-019 SHALL have port stall  output  1  freezes controller state register when 1.
REQ-020 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY, DONE, ERR.
REQ-022 IDLE: when mem_read|mem_write, SHALL latch address (iord ? alu_out : pc), store_data, we = mem_write, dest = ir_write, then go to BUSY; otherwise stay.
REQ-023 mem_write SHALL take priority when mem_read and mem_write are both 1 (store state asserts both): access is a write, and IR/MDR are not loaded.
REQ-024 BUSY: mem_req = 1, mem_we = latched we; on mem_ack SHALL go to DONE, loading mem_rdata into ir (dest = 1) or mdr (dest = 0) on reads only.
REQ-025 BUSY: wait counter SHALL start at 0 on entry and increment each cycle without ack; on reaching TIMEOUT-1 with no ack, SHALL go to ERR.
REQ-026 mem_ack arriving on the same cycle as the timeout limit SHALL win: go to DONE, no error.
REQ-027 DONE: mem_req = 0, stall = 0 for exactly one cycle, then unconditionally IDLE; mem_read/mem_write SHALL be ignored in DONE.
REQ-028 ERR: mem_req = 0, stall = 1, err = 1, held until reset.
REQ-029 stall SHALL be combinational: (IDLE & (mem_read|mem_write)) | BUSY | ERR.
REQ-030 mem_ack outside BUSY SHALL be ignored.
REQ-031 Minimum access latency SHALL be 3 cycles (IDLE detect, BUSY with ack, DONE); ir/mdr SHALL be valid from the DONE cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ir 0, mdr 0, err 0.
REQ-033 Reset mid-BUSY SHALL drop mem_req immediately and discard the access.

Structure
REQ-034 State encoding and TIMEOUT default SHALL live in shared package mem_access_pkg.
REQ-035 Wait counter with limit compare SHALL be sub-module mau_wdog (inputs clear/enable; output expired).

Verification
REQ-036 Fetch: pc = 0x00000040, mem_read = ir_write = 1, ack on 2nd BUSY cycle with rdata 0x8C220004 -> mem_addr 0x40, ir = 0x8C220004 in DONE, stall low only in DONE.
REQ-037 Load: iord = 1, alu_out = 0x00000103 -> mem_addr 0x00000100, mdr updated, ir unchanged.
REQ-038 Store: mem_read = mem_write = 1, store_data = 0xDEADBEEF -> mem_we = 1, mem_wdata 0xDEADBEEF, mdr/ir unchanged.
REQ-039 No ack for 16 cycles -> ERR, err = 1, stall stuck 1; ack on cycle 16 exactly -> DONE, err = 0.
REQ-040 rst_n low during BUSY -> mem_req 0 same cycle, all outputs at reset values; spurious mem_ack in IDLE -> no register change.
